cache_refill_arbiter: RTL and testbench
=======================================

Name: cache_refill_arbiter

Overview:
- Shares the single AXI read-address and read-data channel between the I-cache and D-cache line-refill requesters.
- Grants one requester at a time and issues an 8-beat INCR burst for a 256-bit cache line.
- Assembles the 32-bit beats into one line and returns it to the granted cache with a one-cycle data_ok pulse.
- Sits between both caches and the AXI interface, replacing per-cache burst collectors.

Parameters:
- LINE_WORDS, 8, beats per line; arlen = LINE_WORDS-1.
- DATA_W, 32, AXI data width; line width = LINE_WORDS*DATA_W = 256.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_req  in  1  I-cache refill request; held high until ic_addr_ok.
- ic_addr  in  ADDR_W  I-cache miss address.
- ic_addr_ok  out  1  request accepted, 1-cycle pulse.
- ic_data_ok  out  1  line valid, 1-cycle pulse.
- ic_rdata  out  256  refilled line.
- dc_req, dc_addr, dc_addr_ok, dc_data_ok, dc_rdata  same as ic_* for the D-cache.
- arid  out  4  0 = icache, 1 = dcache.
- araddr  out  ADDR_W  line-aligned address.
- arlen  out  8  LINE_WORDS-1.
- arsize  out  3  3'b010.
- arburst  out  2  2'b01 (INCR).
- arvalid  out  1  AR channel valid.
- arready  in  1  AR channel ready.
- rid  in  4  ignored; only one transaction is ever outstanding.
- rdata  in  DATA_W  read data beat.
- rresp  in  2  read response.
- rlast  in  1  last beat of burst.
- rvalid  in  1  R channel valid.
- rready  out  1  R channel ready.
- bus_err  out  1  1-cycle pulse on a bad burst.

Behaviour:
- Reset:
  - State IDLE; beat count 0; grant pointer set to dcache-first.
  - All outputs 0, including both rdata buses and every AR field.
  - Reset mid-burst abandons the transaction immediately; no data_ok is issued.
- FSM states: IDLE -> AR -> R -> DONE -> IDLE.
- IDLE:
  - If only one requester has req high, select it.
  - If both are high, round-robin: grant the requester not served last. After reset, dcache wins first.
  - On selection, register araddr = addr with bits [4:0] cleared, register arid, and go to AR.
  - In the first AR cycle, drive the granted *_addr_ok high for exactly 1 cycle.
- AR:
  - arvalid = 1; araddr and arid are held stable.
  - On arvalid & arready, go to R. arvalid deasserts the next cycle.
- R:
  - rready = 1.
  - Each rvalid beat k writes rdata to line[32k+31:32k]; k counts 0..7.
  - On a beat with rlast, go to DONE.
  - Error conditions, each raising bus_err for 1 cycle in DONE:
    - rlast arrives with k != 7; the line is delivered anyway and unwritten words keep their stale contents.
    - any beat has rresp != 0.
  - If k reaches 7 without rlast, further beats overwrite word 7 until rlast arrives.
- DONE:
  - Granted *_data_ok = 1 for exactly 1 cycle, with *_rdata valid in that cycle.
  - *_rdata holds its value until the next refill to the same cache.
  - Update the round-robin pointer, then return to IDLE.
  - The next grant can occur in the IDLE cycle immediately after DONE.
- Latency, with arready=1 and rvalid continuous:
  - req sampled in cycle 0; addr_ok and arvalid in cycle 1.
  - Beats in cycles 2..9; data_ok in cycle 10.
- Only one outstanding transaction. A requester not granted sees no addr_ok and simply keeps req high.
- A req dropped before addr_ok is protocol misuse; the arbiter does not check for it.

Decomposition:
- Shared package holds:
  - ARLEN_LINE = 8'd7.
  - ARSIZE_WORD = 3'b010.
  - ARBURST_INCR = 2'b01.
  - ID_ICACHE = 4'd0, ID_DCACHE = 4'd1.
  - State enum {IDLE, AR, R, DONE}.
- Sub-module line_assembler: beat counter plus 256-bit line register.
  - Inputs: clear, beat_valid, beat_data.
  - Outputs: line, count, short_burst flag.
  - The parent instantiates one line_assembler and routes its line to ic_rdata or dc_rdata on data_ok.

Test Plan:
- ic_req, ic_addr=0xBFC0_0014; arready=1; 8 beats 0x11..0x88 with rlast on the 8th → araddr=0xBFC0_0000, arid=0, arlen=7, arburst=1; ic_data_ok in cycle 10; ic_rdata[31:0]=0x11, ic_rdata[255:224]=0x88.
- ic_req and dc_req both high, same cycle, after reset → dcache granted first (arid=1). icache is granted in the IDLE cycle after dc_data_ok. A third simultaneous pair grants dcache again.
- arready low for 3 cycles → arvalid held, araddr stable; no rready beat is accepted before the handshake; completion is delayed by 3 cycles.
- rvalid gaps (beats on alternate cycles) → all 8 words placed correctly in order; data_ok exactly 1 cycle after the rlast beat.
- rlast on beat 5, or rresp=2 on beat 3 → bus_err 1-cycle pulse coincident with data_ok; FSM returns to IDLE and the next request proceeds normally.
- rst asserted during the R state after 4 beats → the next cycle has all outputs 0 and state IDLE; no data_ok; a new ic_req afterwards completes cleanly.

Source files
------------

// File: rtl/cache_refill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_arbiter_pkg
//  Description : Shared constants and FSM encoding for the cache refill
//                arbiter and its line assembler.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_refill_arbiter_pkg;

    // AR channel constants for one 8 x 32-bit INCR line burst
    localparam logic [7:0] ARLEN_LINE   = 8'd7;
    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    // Transaction IDs identify which cache owns the outstanding burst
    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : cache_refill_arbiter_pkg
`default_nettype wire

// File: rtl/cache_refill_arbiter_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_arbiter_line_assembler
//  Description : Collects read-data beats into one cache line. Beat k lands in
//                word k; once the last word is reached further beats keep
//                overwriting it. Flags a burst whose last beat arrives early.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill_arbiter_line_assembler #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    localparam int CNT_W     = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_beat_valid,
    input  logic                         i_beat_last,
    input  logic [DATA_W-1:0]            i_beat_data,
    output logic [LINE_WORDS*DATA_W-1:0] o_line,
    output logic [CNT_W-1:0]             o_count,
    output logic                         o_short_burst
);

    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(LINE_WORDS - 1);

    logic [LINE_WORDS*DATA_W-1:0] r_line;
    logic [CNT_W-1:0]             r_count;
    logic                         r_short;

    // Clear only rewinds the counter: words not rewritten by a short burst
    // intentionally keep their previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line  <= '0;
            r_count <= '0;
            r_short <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_short <= 1'b0;
        end else if (i_beat_valid) begin
            r_line[r_count*DATA_W +: DATA_W] <= i_beat_data;
            if (r_count != c_LAST_WORD) begin
                r_count <= r_count + 1'b1;
            end
            if (i_beat_last && (r_count != c_LAST_WORD)) begin
                r_short <= 1'b1;
            end
        end
    end

    assign o_line        = r_line;
    assign o_count       = r_count;
    assign o_short_burst = r_short;

endmodule : cache_refill_arbiter_line_assembler
`default_nettype wire

// File: rtl/cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_arbiter
//  Description : Shares one AXI AR/R channel pair between the I-cache and
//                D-cache line refills. Round-robin grant, one 8-beat INCR
//                burst at a time, line returned with a 1-cycle data_ok.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    // I-cache refill port
    input  logic                         ic_req,
    input  logic [ADDR_W-1:0]            ic_addr,
    output logic                         ic_addr_ok,
    output logic                         ic_data_ok,
    output logic [LINE_WORDS*DATA_W-1:0] ic_rdata,
    // D-cache refill port
    input  logic                         dc_req,
    input  logic [ADDR_W-1:0]            dc_addr,
    output logic                         dc_addr_ok,
    output logic                         dc_data_ok,
    output logic [LINE_WORDS*DATA_W-1:0] dc_rdata,
    // AXI read address channel
    output logic [3:0]                   arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    // AXI read data channel
    input  logic [3:0]                   rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic                         bus_err
);

    import cache_refill_arbiter_pkg::*;

    localparam int c_LINE_W = LINE_WORDS * DATA_W;
    localparam int c_OFF_W  = $clog2(c_LINE_W / 8);
    localparam int c_CNT_W  = $clog2(LINE_WORDS);

    state_t              r_state;
    state_t              w_next;
    logic                r_grant_dc;   // owner of the current burst
    logic                r_prio_dc;    // tie goes to dcache when set
    logic                r_resp_err;
    logic                r_ic_aok;
    logic                r_dc_aok;
    logic [ADDR_W-1:0]   r_araddr;
    logic [3:0]          r_arid;
    logic [7:0]          r_arlen;
    logic [2:0]          r_arsize;
    logic [1:0]          r_arburst;
    logic [c_LINE_W-1:0] r_ic_line;
    logic [c_LINE_W-1:0] r_dc_line;

    logic                w_any_req;
    logic                w_sel_dc;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_beat;
    logic [c_LINE_W-1:0] w_line;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_short;
    logic                w_unused;

    cache_refill_arbiter_line_assembler #(
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W)
    ) u_line_asm (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (r_state == IDLE),
        .i_beat_valid  (w_beat),
        .i_beat_last   (rlast),
        .i_beat_data   (rdata),
        .o_line        (w_line),
        .o_count       (w_count),
        .o_short_burst (w_short)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, arbitration choice and channel/handshake outputs
    always_comb begin
        w_next     = r_state;
        w_any_req  = ic_req | dc_req;
        w_sel_dc   = dc_req & (~ic_req | r_prio_dc);
        w_sel_addr = w_sel_dc ? dc_addr : ic_addr;
        w_beat     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        ic_data_ok = 1'b0;
        dc_data_ok = 1'b0;
        bus_err    = 1'b0;
        ic_rdata   = r_ic_line;
        dc_rdata   = r_dc_line;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = R;
                end
            end
            R: begin
                rready = 1'b1;
                w_beat = rvalid;
                if (rvalid && rlast) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus_err = r_resp_err | w_short;
                if (r_grant_dc) begin
                    dc_data_ok = 1'b1;
                    dc_rdata   = w_line;
                end else begin
                    ic_data_ok = 1'b1;
                    ic_rdata   = w_line;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant capture, AR fields, addr_ok pulse and round-robin update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_dc <= 1'b0;
            r_prio_dc  <= 1'b1;
            r_ic_aok   <= 1'b0;
            r_dc_aok   <= 1'b0;
            r_araddr   <= '0;
            r_arid     <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
        end else begin
            r_ic_aok <= 1'b0;
            r_dc_aok <= 1'b0;
            if ((r_state == IDLE) && w_any_req) begin
                r_grant_dc <= w_sel_dc;
                r_ic_aok   <= ~w_sel_dc;
                r_dc_aok   <= w_sel_dc;
                r_araddr   <= {w_sel_addr[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
                r_arid     <= w_sel_dc ? ID_DCACHE : ID_ICACHE;
                r_arlen    <= ARLEN_LINE;
                r_arsize   <= ARSIZE_WORD;
                r_arburst  <= ARBURST_INCR;
            end
            if (r_state == DONE) begin
                r_prio_dc <= ~r_grant_dc;
            end
        end
    end

    // Sticky response error for the burst in flight
    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE)) begin
            r_resp_err <= 1'b0;
        end else if (w_beat && (rresp != 2'b00)) begin
            r_resp_err <= 1'b1;
        end
    end

    // Per-cache line hold registers, loaded as the line is delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic_line <= '0;
            r_dc_line <= '0;
        end else if (r_state == DONE) begin
            if (r_grant_dc) begin
                r_dc_line <= w_line;
            end else begin
                r_ic_line <= w_line;
            end
        end
    end

    assign ic_addr_ok = r_ic_aok;
    assign dc_addr_ok = r_dc_aok;
    assign araddr     = r_araddr;
    assign arid       = r_arid;
    assign arlen      = r_arlen;
    assign arsize     = r_arsize;
    assign arburst    = r_arburst;

    // rid is irrelevant with a single outstanding burst; offset bits are dropped
    assign w_unused = ^{rid, w_count, ic_addr[c_OFF_W-1:0], dc_addr[c_OFF_W-1:0]};

endmodule : cache_refill_arbiter
`default_nettype wire

// File: tb/tb_cache_refill_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cache_refill_arbiter
//  Description : Self-checking bench for cache_refill_arbiter. Per-cycle
//                vector tables plus a hand-written reset-mid-burst sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_refill_arbiter;

    localparam logic [31:0] IC_ADDR = 32'hBFC0_0014;
    localparam logic [31:0] IC_LINE = 32'hBFC0_0000;
    localparam logic [31:0] DC_ADDR = 32'h8000_1234;
    localparam logic [31:0] DC_LINE = 32'h8000_1220;

    // Expected output bits: {ic_addr_ok, dc_addr_ok, arvalid, rready, ic_data_ok, dc_data_ok, bus_err}
    localparam logic [6:0] E_IDLE   = 7'b0000000;
    localparam logic [6:0] E_AOK_IC = 7'b1010000;
    localparam logic [6:0] E_AOK_DC = 7'b0110000;
    localparam logic [6:0] E_ARV    = 7'b0010000;
    localparam logic [6:0] E_RR     = 7'b0001000;
    localparam logic [6:0] E_DOK_IC = 7'b0000100;
    localparam logic [6:0] E_DOK_DC = 7'b0000010;
    localparam logic [6:0] E_ERR    = 7'b0000001;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_req, dc_req;
    logic [31:0]  ic_addr, dc_addr;
    logic         ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok;
    logic [255:0] ic_rdata, dc_rdata;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready, bus_err;

    always #5 clk = ~clk;

    cache_refill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_addr_ok (ic_addr_ok),
        .ic_data_ok (ic_data_ok),
        .ic_rdata   (ic_rdata),
        .dc_req     (dc_req),
        .dc_addr    (dc_addr),
        .dc_addr_ok (dc_addr_ok),
        .dc_data_ok (dc_data_ok),
        .dc_rdata   (dc_rdata),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic         icr;
        logic         dcr;
        logic         ar;
        logic         rv;
        logic         rl;
        logic [1:0]   rr;
        logic [31:0]  d;
        logic [6:0]   ex;
        logic         id;
        logic [255:0] line;
    } vec_t;

    vec_t         tbl[$];
    logic [255:0] m_line;   // expected contents of the line buffer
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ic_req = 1'b0; dc_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rlast = 1'b0; rresp = 2'b00; rdata = '0; rid = '0;
    endtask

    task automatic push_idle(input int n);
        vec_t v;
        v = '{default: '0};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // One refill: request cycle, AR (with optional stall), nlast beats (optional
    // idle gaps), delivery cycle. 'other' keeps the other cache requesting.
    task automatic push_txn(input bit dc, input bit other, input int stall, input bit gaps,
                            input int nlast, input int err_beat, input logic [31:0] base);
        vec_t v;
        v     = '{default: '0};
        v.id  = dc;
        v.icr = dc ? other : 1'b1;
        v.dcr = dc ? 1'b1 : other;
        v.ex  = E_IDLE;
        tbl.push_back(v);
        v.ar  = (stall == 0);
        v.ex  = dc ? E_AOK_DC : E_AOK_IC;
        tbl.push_back(v);
        if (dc) v.dcr = 1'b0; else v.icr = 1'b0;
        for (int s = 1; s <= stall; s++) begin
            v.ar = (s == stall); v.rv = 1'b1; v.d = 32'hDEAD_BEEF; v.ex = E_ARV;
            tbl.push_back(v);
        end
        v.ar = 1'b0;
        for (int b = 0; b < nlast; b++) begin
            if (gaps && b > 0) begin
                v.rv = 1'b0; v.rl = 1'b0; v.rr = 2'd0; v.d = '0; v.ex = E_RR;
                tbl.push_back(v);
            end
            v.rv = 1'b1;
            v.rl = (b == nlast - 1);
            v.rr = (b == err_beat) ? 2'd2 : 2'd0;
            v.d  = base * (b + 1);
            v.ex = E_RR;
            tbl.push_back(v);
            m_line[b*32 +: 32] = base * (b + 1);
        end
        v.rv = 1'b0; v.rl = 1'b0; v.rr = 2'd0; v.d = '0;
        v.ex = (dc ? E_DOK_DC : E_DOK_IC) | (((err_beat >= 0) || (nlast != 8)) ? E_ERR : E_IDLE);
        v.line = m_line;
        tbl.push_back(v);
    endtask

    // Entered just after a rising edge; leaves just after a rising edge
    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            ic_req = tbl[i].icr; dc_req = tbl[i].dcr; arready = tbl[i].ar;
            rvalid = tbl[i].rv;  rlast  = tbl[i].rl;  rresp   = tbl[i].rr;
            rdata  = tbl[i].d;
            @(negedge clk);
            check({tag, " handshakes"},
                  {249'd0, ic_addr_ok, dc_addr_ok, arvalid, rready, ic_data_ok, dc_data_ok, bus_err},
                  {249'd0, tbl[i].ex});
            if (tbl[i].ex[4])
                check({tag, " ar_fields"}, {207'd0, araddr, arid, arlen, arsize, arburst},
                      {207'd0, (tbl[i].id ? DC_LINE : IC_LINE), {3'd0, tbl[i].id}, 8'd7, 3'b010, 2'b01});
            if (tbl[i].ex[2]) check({tag, " ic_line"}, ic_rdata, tbl[i].line);
            if (tbl[i].ex[1]) check({tag, " dc_line"}, dc_rdata, tbl[i].line);
            @(posedge clk); #1;
        end
        tbl.delete();
        drive_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_line = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        ic_addr = IC_ADDR;
        dc_addr = DC_ADDR;
        m_line  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_all_zero",
              {255'd0, |{ic_addr_ok, ic_data_ok, ic_rdata, dc_addr_ok, dc_data_ok, dc_rdata,
                         arid, araddr, arlen, arsize, arburst, arvalid, rready, bus_err}}, 256'd0);
        rst = 1'b0;

        // Single icache refill, continuous beats 0x11..0x88, data_ok in cycle 10
        push_txn(1'b0, 1'b0, 0, 1'b0, 8, -1, 32'h11);
        push_idle(1);
        run_table("basic");
        check("basic ic_word0_held", {224'd0, ic_rdata[31:0]}, 256'h11);
        check("basic ic_word7_held", {224'd0, ic_rdata[255:224]}, 256'h88);

        // dcache refill with arready low for three cycles and rvalid offered early
        push_txn(1'b1, 1'b0, 3, 1'b0, 8, -1, 32'h0202_0202);
        push_idle(1);
        run_table("stall");

        // icache refill with beats on alternate cycles
        push_txn(1'b0, 1'b0, 0, 1'b1, 8, -1, 32'h0303_0303);
        run_table("gaps");

        // rlast on the 5th beat: words 5..7 keep the previous line's data
        push_txn(1'b0, 1'b0, 0, 1'b0, 5, -1, 32'h0404_0404);
        push_idle(1);
        run_table("short");
        check("short ic_stale_word7", {224'd0, ic_rdata[255:224]}, {224'd0, 32'h0303_0303 * 8});

        // rresp error on beat 3, then a clean icache refill
        push_txn(1'b1, 1'b0, 0, 1'b0, 8, 2, 32'h0505_0505);
        push_txn(1'b0, 1'b0, 0, 1'b0, 8, -1, 32'h0606_0606);
        push_idle(1);
        run_table("rresp");

        // Round-robin after reset: dcache, icache, dcache
        do_reset();
        push_txn(1'b1, 1'b1, 0, 1'b0, 8, -1, 32'h0707_0707);
        push_txn(1'b0, 1'b0, 0, 1'b0, 8, -1, 32'h0808_0808);
        push_txn(1'b1, 1'b1, 0, 1'b0, 8, -1, 32'h0909_0909);
        push_idle(2);
        run_table("rr");

        // Reset during the R state after four beats
        ic_req = 1'b1;
        @(posedge clk); #1;
        arready = 1'b1;
        @(posedge clk); #1;
        ic_req = 1'b0; arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rdata = 32'hC0DE_0000 + b;
            @(negedge clk);
            check("rst_mid rready", {255'd0, rready}, 256'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1; rvalid = 1'b1; rdata = 32'hC0DE_0004;
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        check("rst_mid_all_zero",
              {255'd0, |{ic_addr_ok, ic_data_ok, ic_rdata, dc_addr_ok, dc_data_ok, dc_rdata,
                         arid, araddr, arlen, arsize, arburst, arvalid, rready, bus_err}}, 256'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_mid no_data_ok", {254'd0, ic_data_ok, dc_data_ok}, 256'd0);
        end
        @(posedge clk); #1;
        m_line = '0;
        push_txn(1'b0, 1'b0, 0, 1'b0, 8, -1, 32'h0A0A_0A0A);
        push_idle(1);
        run_table("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cache_refill_arbiter
`default_nettype wire
